serial_word_receiver: RTL
=========================

# serial_word_receiver

Serial-to-parallel deserializer that rebuilds word_size-bit words from a one-bit stream produced by the team's shift-register transmitters (either end: MSB-first or LSB-first). Each word is assembled in an internal shift register, then placed in a one-entry output buffer with a valid/ready handshake. It sits on the receive side of any serial link driven from a universal shift register's serial output.

## Interface
- word_size, 4, word width in bits; legal range ≥ 2
- clk  in  1  rising-edge clock, only clock of the block
- rst  in  1  reset, synchronous, active-high
- Serial_In  in  1  serial data bit
- Bit_Valid  in  1  1 = sample Serial_In at this edge
- Dir  in  1  0 = MSB-first stream, 1 = LSB-first stream; sampled with the first bit of each word
- Clear  in  1  synchronous abort of the partial word in progress
- Data_Ready  in  1  consumer accepts Data_Out when high with Data_Valid
- Data_Out  out  word_size  assembled word (output buffer)
- Data_Valid  out  1  output buffer holds an unconsumed word
- Busy  out  1  partial word in progress (bit count ≠ 0)
- Overrun  out  1  sticky: a completed word was dropped

## Operation
- State: shift register sr[word_size-1:0], bit counter cnt (0..word_size-1), latched direction dir_q, output buffer Data_Out, Data_Valid, Overrun.
- Idle/collecting behaviour, per rising edge with Bit_Valid=1 and Clear=0:
  - cnt==0: dir_q <= Dir; the bit uses the new Dir.
  - Direction 0 (MSB-first): sr <= {sr[word_size-2:0], Serial_In}, first bit ends in MSB.
  - Direction 1 (LSB-first): sr <= {Serial_In, sr[word_size-1:1]}, first bit ends in LSB.
  - cnt < word_size-1: cnt <= cnt+1.
  - cnt == word_size-1 (last bit): cnt <= 0; completed word = shifted value including this bit.
- Word completion:
  - Buffer free (Data_Valid=0, or Data_Valid=1 and Data_Ready=1 same edge): Data_Out <= completed word, Data_Valid <= 1.
  - Buffer occupied and not draining: completed word discarded, Data_Out unchanged, Overrun <= 1.
- Handshake: transfer occurs at an edge where Data_Valid=1 and Data_Ready=1; Data_Valid then falls to 0 unless a word completes at the same edge (then stays 1 with the new word). Data_Out is stable while Data_Valid=1 and not transferred.
- Dir changes while cnt≠0 are ignored (dir_q governs the word).
- Bit_Valid=0: sr, cnt, dir_q hold.
- Clear=1: cnt <= 0, sr <= 0; Bit_Valid this edge discarded (Clear wins). Data_Out, Data_Valid, Overrun unaffected; handshake still proceeds.
- Busy = (cnt ≠ 0), combinational from state.
- Overrun clears only on rst.

## Timing
- Reset (rst=1 at edge): Data_Out=0, Data_Valid=0, Overrun=0, Busy=0, sr=0, cnt=0, dir_q=0. rst overrides all inputs including Data_Ready; a partial word is lost.
- Latency: last bit sampled at edge N → Data_Out/Data_Valid valid after edge N (one edge, no extra pipeline).
- Throughput: one word per word_size Bit_Valid cycles back-to-back, no gap required between words, provided Data_Ready is high at least once per word.
- Bits may be separated by any number of Bit_Valid=0 cycles.
- No combinational path from inputs to outputs.

## Test plan
- word_size=4, Dir=0, bits 1,0,1,1 on consecutive edges → after 4th edge Data_Out=4'b1011, Data_Valid=1, Busy=0; Data_Ready=1 next edge → Data_Valid=0.
- Dir=1, bits 1,0,1,1 → Data_Out=4'b1101; toggle Dir after the first bit → result unchanged.
- Bits 0,1,1,0 with 2 idle cycles between each (Dir=0) → Data_Out=4'b0110 only after the 4th valid bit; Busy=1 during gaps.
- Data_Ready=0; send 4'b1010 then 4'b0101 (Dir=0) → Data_Out stays 4'b1010, Overrun=1 after the 8th bit; raise Data_Ready → Data_Valid=0, Overrun still 1 until rst.
- Data_Valid=1 holding 4'b1111, Data_Ready=1 at exactly the edge of the last bit of 4'b0011 → Data_Out=4'b0011, Data_Valid stays 1, Overrun=0.
- Two bits in, then Clear=1 with Bit_Valid=1 → Busy=0; next 4 bits 1,1,0,0 give 4'b1100; repeat with rst after 2 bits → all outputs 0.

Source files
------------

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: rebuilds word_size-bit words from a serial stream
// (MSB- or LSB-first) into a one-entry valid/ready output buffer.
module serial_word_receiver #(
  parameter int word_size = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Serial_In,
  input  logic                 Bit_Valid,
  input  logic                 Dir,
  input  logic                 Clear,
  input  logic                 Data_Ready,
  output logic [word_size-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 Busy,
  output logic                 Overrun
);

  localparam int CW = (word_size > 2) ? $clog2(word_size) : 1;
  localparam logic [CW-1:0] LAST = CW'(word_size - 1);

  logic [CW-1:0]        cnt;
  logic [word_size-1:0] sr;
  logic [word_size-1:0] sr_nxt;
  logic                 dir_q;
  logic                 dir_eff;
  logic                 last;
  logic                 done;
  logic                 buf_free;

  // Next shift value; the first bit of a word follows the live Dir input
  always_comb begin
    dir_eff  = (cnt == '0) ? Dir : dir_q;
    sr_nxt   = dir_eff ? {Serial_In, sr[word_size-1:1]}
                       : {sr[word_size-2:0], Serial_In};
    last     = (cnt == LAST);
    done     = Bit_Valid && !Clear && last;
    buf_free = !Data_Valid || Data_Ready;
  end

  // Bit collector: shift register, bit counter and latched direction
  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (Clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (Bit_Valid) begin
      if (cnt == '0) dir_q <= Dir;
      sr  <= sr_nxt;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Output buffer with handshake and sticky overrun on a dropped word
  always_ff @(posedge clk) begin
    if (rst) begin
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
      Overrun    <= 1'b0;
    end else if (done) begin
      if (buf_free) begin
        Data_Out   <= sr_nxt;
        Data_Valid <= 1'b1;
      end else begin
        Overrun <= 1'b1;
      end
    end else if (Data_Valid && Data_Ready) begin
      Data_Valid <= 1'b0;
    end
  end

  // Partial word in progress
  always_comb Busy = (cnt != '0);

endmodule
